bus_master_port: RTL and testbench
==================================

BUS_MASTER_PORT -- requirements
Module: bus_master_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, request FIFO depth (power of 2, >=2).
REQ-002 SHALL have parameter MAX_OUT, default 4, maximum outstanding bus requests (>=1).
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles with no ack/err while outstanding>0 before abort.
REQ-004 SHALL have ports: clk  in  1  clock; all state on rising edge.
REQ-005 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: req_valid  in  1  client request present.
REQ-007 SHALL have ports: req_ready  out  1  FIFO can accept request.
REQ-008 SHALL have ports: req_we  in  1  write (1) / read (0).
REQ-009 SHALL have ports: req_addr  in  WORD_SIZE-2  word address.
REQ-010 SHALL have ports: req_data  in  WORD_SIZE  write data.
REQ-011 SHALL have ports: req_sel  in  width of bus::m2s_s.sel  byte select.
REQ-012 SHALL have ports: rsp_valid  out  1  one-cycle response pulse, no backpressure.
REQ-013 SHALL have ports: rsp_data  out  WORD_SIZE  read data, valid with rsp_valid.
REQ-014 SHALL have ports: rsp_err  out  1  bus error or timeout, valid with rsp_valid.
REQ-015 SHALL have ports: bus_o  out  bus::m2s_s  master-to-interconnect.
REQ-016 SHALL have ports: bus_i  in  bus::s2m_s  interconnect-to-master.

Function
REQ-017 SHALL accept a request when req_valid && req_ready; req_ready = FIFO not full && state!=ABORT.
REQ-018 SHALL issue the FIFO head on bus_o (addr, data, we, sel) with stb=1 when state==BUSY and outstanding<MAX_OUT.
REQ-019 SHALL pop the head and increment outstanding on the cycle stb && !bus_i.stall; on stall, hold all bus_o fields unchanged.
REQ-020 SHALL decrement outstanding on bus_i.ack || bus_i.err while outstanding>0; issue and response in the same cycle leave it unchanged.
REQ-021 SHALL ignore ack/err when outstanding==0 (no rsp_valid, no counter change).
REQ-022 SHALL drive rsp_valid = (ack||err) && outstanding>0 combinationally, with rsp_data=bus_i.data and rsp_err=bus_i.err, responses in issue order.
REQ-023 SHALL have states IDLE (cyc=0), BUSY (cyc=1), ABORT (cyc=0).
REQ-024 SHALL transition IDLE->BUSY when the FIFO is non-empty.
REQ-025 SHALL transition BUSY->IDLE when the FIFO is empty, outstanding==0 and no issue occurs this cycle.
REQ-026 SHALL transition BUSY->ABORT when the watchdog reaches TIMEOUT.
REQ-027 SHALL stay in ABORT for one rsp_valid pulse (rsp_err=1) per outstanding request, one per cycle, then go to IDLE with outstanding=0.
REQ-028 SHALL run the watchdog only while outstanding>0, clear it on any ack/err or issue, and saturate it at TIMEOUT.
REQ-029 SHALL drive stb=0 whenever cyc=0.
REQ-030 SHALL keep FIFO contents unchanged across ABORT; pending requests are issued after returning to IDLE->BUSY.
REQ-031 SHALL, with FIFO full, accept a push on the same cycle as a pop.
REQ-032 SHALL wrap FIFO pointers modulo DEPTH, with full/empty distinguished by an extra pointer bit.
REQ-033 SHALL size the outstanding counter to $clog2(MAX_OUT+1) bits; it never exceeds MAX_OUT.

Reset
REQ-034 SHALL, while rst=0, clear state to IDLE and zero the FIFO pointers, outstanding count and watchdog.
REQ-035 SHALL hold bus_o at null (all fields 0), req_ready=0 and rsp_valid=0 while rst=0.
REQ-036 SHALL, after rst deasserts, drive req_ready=1.
REQ-037 SHALL, on reset mid-transaction, discard all queued and outstanding requests with no responses generated.

Structure
REQ-038 SHALL place the state enum and the null m2s constant in package bus; WORD_SIZE comes from jpu_defines.vh.
REQ-039 SHALL implement the request FIFO as sub-module bus_req_fifo (DEPTH, payload width parameters).

Verification
REQ-040 SHALL verify: single read addr 0x10, ack next cycle with data 0xDEADBEEF -> one rsp_valid, rsp_data=0xDEADBEEF, rsp_err=0; cyc drops the following cycle.
REQ-041 SHALL verify: 4 back-to-back writes, stall=1 for 3 cycles on the second -> bus_o held during the stall, 4 acks, 4 rsp_valid in order, outstanding returns to 0.
REQ-042 SHALL verify: 6 reads with MAX_OUT=4 and acks withheld -> stb deasserts after 4 issues and resumes after the first ack.
REQ-043 SHALL verify: err on the 2nd of 3 reads -> rsp_err pattern 0,1,0.
REQ-044 SHALL verify: 2 issued reads, no ack for TIMEOUT=8 cycles -> ABORT, 2 pulses with rsp_err=1, cyc=0, then IDLE.
REQ-045 SHALL verify: rst=0 asserted with 3 outstanding -> bus_o null immediately; after release, no rsp_valid and req_ready=1.

Source files
------------

// File: rtl/bus_pkg.sv
// bus: shared types for the bus master port: bus structs, master state and the null request.
package bus;
  localparam int WORD_SIZE = 32;
  localparam int ADDR_W = WORD_SIZE - 2;
  localparam int SEL_W = WORD_SIZE / 8;
  typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_e;
  typedef struct packed {
    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_SIZE-1:0] data;
    logic [SEL_W-1:0]     sel;
  } m2s_s;
  typedef struct packed {
    logic                 ack;
    logic                 err;
    logic                 stall;
    logic [WORD_SIZE-1:0] data;
  } s2m_s;
  // Field order matches the tail of m2s_s so a queued request drops straight onto the bus.
  typedef struct packed {
    logic                 we;
    logic [ADDR_W-1:0]    addr;
    logic [WORD_SIZE-1:0] data;
    logic [SEL_W-1:0]     sel;
  } req_s;
  localparam m2s_s M2S_NULL = '0;
endpackage

// File: rtl/bus_req_fifo.sv
// bus_req_fifo: request queue with extra-bit pointers; a push when full is taken if a pop happens the same cycle.
module bus_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = wp == {~rp[AW], rp[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + (AW+1)'(do_push);
      rp <= rp + (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/bus_master_port.sv
// bus_master_port: queued pipelined bus master with an outstanding-request limit and a watchdog abort.
module bus_master_port import bus::*; #(
  parameter int DEPTH = 4,
  parameter int MAX_OUT = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [WORD_SIZE-1:0] req_data,
  input  logic [SEL_W-1:0]     req_sel,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_err,
  output m2s_s                 bus_o,
  input  s2m_s                 bus_i
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [OW-1:0] MAX_C = OW'(MAX_OUT);
  localparam logic [WW-1:0] TO_C = WW'(TIMEOUT);
  state_e state, state_nxt;
  logic [OW-1:0] out, out_nxt;
  logic [WW-1:0] wd, wd_nxt;
  req_s head;
  logic full, empty, push, stb, issue, bus_rsp, abort_rsp;
  assign req_ready = rst && !full && state != ABORT;
  assign push = req_valid && req_ready;
  assign stb = state == BUSY && !empty && out < MAX_C;
  assign issue = stb && !bus_i.stall;
  assign bus_rsp = (bus_i.ack || bus_i.err) && out != '0 && state != ABORT;
  assign abort_rsp = state == ABORT && out != '0;
  assign rsp_valid = bus_rsp || abort_rsp;
  assign rsp_data = bus_rsp ? bus_i.data : '0;
  assign rsp_err = abort_rsp || (bus_rsp && bus_i.err);
  // Payload fields are only driven while strobing, so an idle or aborted bus reads as null.
  assign bus_o = {state == BUSY, stb, stb ? head : req_s'('0)};
  bus_req_fifo #(.DEPTH(DEPTH), .W($bits(req_s))) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din({req_we, req_addr, req_data, req_sel}),
    .pop(issue),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_comb begin
    out_nxt = out + OW'(issue) - OW'(rsp_valid);
    wd_nxt = (state != BUSY || out == '0 || bus_i.ack || bus_i.err || issue) ? '0 : wd + WW'(wd != TO_C);
    state_nxt = state == IDLE ? (empty ? IDLE : BUSY) :
                state == BUSY ? (wd == TO_C ? ABORT : (empty && out == '0 && !issue) ? IDLE : BUSY) :
                (out > OW'(1) ? ABORT : IDLE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      out <= '0;
      wd <= '0;
    end else begin
      state <= state_nxt;
      out <= out_nxt;
      wd <= wd_nxt;
    end
endmodule

// File: tb/tb_bus_master_port.sv
// tb_bus_master_port: directed vector table plus multi-cycle sequences for the bus master port.
module tb_bus_master_port;
  import bus::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [WORD_SIZE-1:0] req_data = '0;
  logic [SEL_W-1:0] req_sel = '0;
  logic req_ready, rsp_valid, rsp_err;
  logic [WORD_SIZE-1:0] rsp_data;
  m2s_s bus_o, held;
  s2m_s bus_i = '0;
  int n_chk = 0;
  int n_fail = 0;
  int pushed, n_push, issued;
  logic [ADDR_W-1:0] base;
  logic [WORD_SIZE-1:0] rq[$];
  logic eq[$];

  typedef struct {
    logic v; logic [ADDR_W-1:0] a; logic ack; logic err; logic [WORD_SIZE-1:0] rd;
    logic rdy; logic cyc; logic stb; logic [ADDR_W-1:0] ba; logic rv; logic re; logic [WORD_SIZE-1:0] rdat;
  } vec_t;
  vec_t vt[14];

  always #5 clk = ~clk;

  bus_master_port #(.DEPTH(4), .MAX_OUT(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_data(req_data), .req_sel(req_sel), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .bus_o(bus_o), .bus_i(bus_i)
  );

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic we, input logic [ADDR_W-1:0] a, input logic [WORD_SIZE-1:0] d,
                       input logic ack, input logic err, input logic stall, input logic [WORD_SIZE-1:0] rd);
    @(negedge clk);
    req_valid = v; req_we = we; req_addr = a; req_data = d; req_sel = '1;
    bus_i = '{ack: ack, err: err, stall: stall, data: rd};
    #1;
    if (rsp_valid) begin
      rq.push_back(rsp_data);
      eq.push_back(rsp_err);
    end
  endtask

  task automatic pdrive(input logic ack, input logic [WORD_SIZE-1:0] rd);
    drive(pushed < n_push, 1'b0, base + ADDR_W'(pushed), '0, ack, 1'b0, 1'b0, rd);
    if (req_valid && req_ready) pushed++;
    if (bus_o.stb) issued++;
  endtask

  task automatic start_seq(input int n, input logic [ADDR_W-1:0] b);
    rq.delete(); eq.delete();
    pushed = 0; issued = 0; n_push = n; base = b;
  endtask

  task automatic wait_cyc_low(input string name);
    for (int k = 0; k < 8 && bus_o.cyc; k++) drive(0, 0, '0, '0, 0, 0, 0, '0);
    check(name, 128'(bus_o.cyc), 128'(0));
  endtask

  initial begin
    //         v  a      ack err rd            rdy cyc stb ba     rv re rdat
    vt[0]  = '{1, 'h10, 0, 0, 0,            1, 0, 0, 0,     0, 0, 0};
    vt[1]  = '{0, 0,    0, 0, 0,            1, 0, 0, 0,     0, 0, 0};
    vt[2]  = '{0, 0,    0, 0, 0,            1, 1, 1, 'h10,  0, 0, 0};
    vt[3]  = '{0, 0,    1, 0, 'hDEADBEEF,   1, 1, 0, 0,     1, 0, 'hDEADBEEF};
    vt[4]  = '{0, 0,    0, 0, 0,            1, 1, 0, 0,     0, 0, 0};
    vt[5]  = '{1, 'h20, 0, 0, 0,            1, 0, 0, 0,     0, 0, 0};
    vt[6]  = '{1, 'h21, 0, 0, 0,            1, 0, 0, 0,     0, 0, 0};
    vt[7]  = '{1, 'h22, 0, 0, 0,            1, 1, 1, 'h20,  0, 0, 0};
    vt[8]  = '{0, 0,    1, 0, 'h11111111,   1, 1, 1, 'h21,  1, 0, 'h11111111};
    vt[9]  = '{0, 0,    0, 1, 0,            1, 1, 1, 'h22,  1, 1, 0};
    vt[10] = '{0, 0,    1, 0, 'h33333333,   1, 1, 0, 0,     1, 0, 'h33333333};
    vt[11] = '{0, 0,    0, 0, 0,            1, 1, 0, 0,     0, 0, 0};
    vt[12] = '{0, 0,    1, 0, 'h44,         1, 0, 0, 0,     0, 0, 0};
    vt[13] = '{0, 0,    0, 1, 0,            1, 0, 0, 0,     0, 0, 0};

    bus_i = '{ack: 1'b1, err: 1'b0, stall: 1'b0, data: 'hFFFF};
    req_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_bus_null", 128'(bus_o), 128'(0));
    check("rst_ready", 128'(req_ready), 128'(0));
    check("rst_rsp", 128'(rsp_valid), 128'(0));
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; bus_i = '0;

    for (int i = 0; i < 14; i++) begin
      drive(vt[i].v, 1'b0, vt[i].a, '0, vt[i].ack, vt[i].err, 1'b0, vt[i].rd);
      check($sformatf("vec%0d", i),
            128'({req_ready, bus_o.cyc, bus_o.stb, bus_o.stb ? bus_o.addr : ADDR_W'(0),
                  rsp_valid, rsp_valid ? rsp_err : 1'b0, rsp_valid ? rsp_data : WORD_SIZE'(0)}),
            128'({vt[i].rdy, vt[i].cyc, vt[i].stb, vt[i].ba, vt[i].rv, vt[i].re, vt[i].rdat}));
    end

    start_seq(4, 'h40);
    drive(1, 1, 'h40, 'hA0, 0, 0, 0, '0);
    drive(1, 1, 'h41, 'hA1, 0, 0, 0, '0);
    drive(1, 1, 'h42, 'hA2, 0, 0, 0, '0);
    check("wr_issue0", 128'({bus_o.stb, bus_o.we, bus_o.addr, bus_o.data}), 128'({2'b11, ADDR_W'('h40), 32'hA0}));
    drive(1, 1, 'h43, 'hA3, 0, 0, 1, '0);
    held = bus_o;
    check("wr_stall_w1", 128'({bus_o.stb, bus_o.we, bus_o.addr, bus_o.data, bus_o.sel}),
          128'({2'b11, ADDR_W'('h41), 32'hA1, 4'hF}));
    drive(0, 0, '0, '0, 1, 0, 1, 'hB0);
    check("wr_hold1", 128'(bus_o), 128'(held));
    drive(0, 0, '0, '0, 0, 0, 1, '0);
    check("wr_hold2", 128'(bus_o), 128'(held));
    drive(0, 0, '0, '0, 0, 0, 0, '0);
    check("wr_release", 128'(bus_o), 128'(held));
    drive(0, 0, '0, '0, 1, 0, 0, 'hB1);
    drive(0, 0, '0, '0, 1, 0, 0, 'hB2);
    drive(0, 0, '0, '0, 1, 0, 0, 'hB3);
    check("wr_rsp_count", 128'(rq.size()), 128'(4));
    for (int i = 0; i < 4 && i < rq.size(); i++)
      check($sformatf("wr_rsp%0d", i), 128'({eq[i], rq[i]}), 128'({1'b0, WORD_SIZE'('hB0 + i)}));
    wait_cyc_low("wr_cyc_drop");

    start_seq(6, 'h60);
    for (int k = 0; k < 20 && issued < 4; k++) pdrive(0, '0);
    check("rd_four_issued", 128'(issued), 128'(4));
    for (int k = 0; k < 3; k++) begin
      pdrive(0, '0);
      check($sformatf("rd_limit%0d", k), 128'(bus_o.stb), 128'(0));
    end
    pdrive(1, 'h100);
    check("rd_stb_at_ack", 128'(bus_o.stb), 128'(0));
    pdrive(0, '0);
    check("rd_stb_resume", 128'({bus_o.stb, bus_o.addr}), 128'({1'b1, ADDR_W'('h64)}));
    for (int k = 0; k < 30 && rq.size() < 6; k++) pdrive(1, WORD_SIZE'('h101 + k));
    check("rd_rsp_count", 128'(rq.size()), 128'(6));
    wait_cyc_low("rd_cyc_drop");

    start_seq(2, 'h80);
    for (int k = 0; k < 20 && issued < 2; k++) pdrive(0, '0);
    check("to_two_issued", 128'(issued), 128'(2));
    for (int k = 0; k < 40 && !rsp_valid; k++) pdrive(0, '0);
    check("to_pulse1", 128'({rsp_valid, bus_o.cyc, rsp_err, req_ready}), 128'(4'b1010));
    pdrive(0, '0);
    check("to_pulse2", 128'({rsp_valid, bus_o.cyc, rsp_err, bus_o.stb}), 128'(4'b1010));
    pdrive(0, '0);
    check("to_idle", 128'({rsp_valid, req_ready, bus_o.cyc}), 128'(3'b010));

    start_seq(3, 'hC0);
    for (int k = 0; k < 20 && issued < 3; k++) pdrive(0, '0);
    check("rm_three_issued", 128'(issued), 128'(3));
    @(negedge clk);
    req_valid = 1'b0;
    bus_i = '{ack: 1'b1, err: 1'b0, stall: 1'b0, data: 'h55};
    rst = 1'b0;
    #1;
    check("rm_bus_null", 128'(bus_o), 128'(0));
    check("rm_ready_low", 128'({req_ready, rsp_valid}), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    rq.delete();
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, '0, '0, 1, 0, 0, 'h55);
      check($sformatf("rm_after%0d", k), 128'({req_ready, bus_o.cyc}), 128'(2'b10));
    end
    check("rm_no_rsp", 128'(rq.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
